// File: rtl/mips_defs.sv
// Shared syscall service codes and FSM state encoding for the syscall unit.
package mips_defs;

    localparam logic [31:0] SYS_PRINT_INT = 32'd1;
    localparam logic [31:0] SYS_PRINT_HEX = 32'd34;
    localparam logic [31:0] SYS_SLEEP     = 32'd32;
    localparam logic [31:0] SYS_EXIT      = 32'd10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRINT = 2'd1,
        ST_SLEEP = 2'd2,
        ST_HALT  = 2'd3
    } sys_state_t;

    function automatic logic is_print(input logic [31:0] code);
        return (code == SYS_PRINT_INT) || (code == SYS_PRINT_HEX);
    endfunction

endpackage

// File: rtl/sleep_timer.sv
// Sleep duration timer: TICK_DIV prescaler feeding a 32-bit down-counter.
module sleep_timer #(
    parameter int TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        en,
    input  logic [31:0] value,
    output logic        done
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [31:0]   cnt;
    logic [TW-1:0] tick;
    logic          wrap;

    assign wrap = (tick == TICK_LAST);
    // done flags the final tick so the FSM leaves on the edge cnt hits zero
    assign done = en && wrap && (cnt == 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= '0;
        end else if (load) begin
            cnt  <= value;
            tick <= '0;
        end else if (en) begin
            if (wrap) begin
                tick <= '0;
                if (cnt != 32'd0) cnt <= cnt - 32'd1;
            end else begin
                tick <= tick + TW'(1);
            end
        end
    end

endmodule

// File: rtl/syscall_unit.sv
// Executes MIPS-style syscalls: print via valid/ready, sleep, halt, or no-op.
module syscall_unit
    import mips_defs::*;
#(
    parameter int TICK_DIV = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             syscall,
    input  logic [31:0]      v0,
    input  logic [31:0]      a0,
    input  logic             disp_ready,
    input  logic             go,
    output logic             stall,
    output logic             halted,
    output logic [31:0]      disp_data,
    output logic             disp_valid,
    output logic [CNT_W-1:0] sys_count
);
    sys_state_t state;
    logic accept, do_print, do_sleep, do_exit, sleep_done;

    // Syscalls outside IDLE are protocol violations and are dropped here.
    assign accept   = syscall && (state == ST_IDLE);
    assign do_print = accept && is_print(v0);
    assign do_sleep = accept && (v0 == SYS_SLEEP) && (a0 != 32'd0);
    assign do_exit  = accept && (v0 == SYS_EXIT);

    assign stall = (state != ST_IDLE) || do_print || do_sleep || do_exit;

    sleep_timer #(.TICK_DIV(TICK_DIV)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (do_sleep),
        .en    (state == ST_SLEEP),
        .value (a0),
        .done  (sleep_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            halted     <= 1'b0;
            disp_data  <= '0;
            disp_valid <= 1'b0;
            sys_count  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) sys_count <= sys_count + CNT_W'(1);
                    if (do_print) begin
                        disp_data  <= a0;
                        disp_valid <= 1'b1;
                        state      <= ST_PRINT;
                    end else if (do_sleep) begin
                        state <= ST_SLEEP;
                    end else if (do_exit) begin
                        halted <= 1'b1;
                        state  <= ST_HALT;
                    end
                end
                ST_PRINT: begin
                    if (disp_ready) begin
                        disp_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                ST_SLEEP: begin
                    if (sleep_done) state <= ST_IDLE;
                end
                ST_HALT: begin
                    if (go) begin
                        halted <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_syscall_unit.sv
// Directed bench for syscall_unit with TICK_DIV=4.
module tb_syscall_unit;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             syscall = 1'b0;
    logic [31:0]      v0 = '0;
    logic [31:0]      a0 = '0;
    logic             disp_ready = 1'b0;
    logic             go = 1'b0;
    logic             stall, halted, disp_valid;
    logic [31:0]      disp_data;
    logic [CNT_W-1:0] sys_count;

    int n_chk = 0;
    int n_pass = 0;

    syscall_unit #(.TICK_DIV(4), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .syscall    (syscall),
        .v0         (v0),
        .a0         (a0),
        .disp_ready (disp_ready),
        .go         (go),
        .stall      (stall),
        .halted     (halted),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .sys_count  (sys_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Issue one syscall at a falling edge and count stalled cycles (bounded).
    // viol_at >= 0 re-pulses syscall on that stall cycle as a protocol violation.
    task automatic run_sys(input logic [31:0] v, input logic [31:0] a,
                           input int viol_at, output int n);
        n = 0;
        @(negedge clk);
        syscall = 1'b1; v0 = v; a0 = a;
        #1;
        while (stall && n < 200) begin
            n++;
            @(negedge clk);
            syscall = (n == viol_at);
            v0 = (n == viol_at) ? 32'd1 : v;
            #1;
        end
        @(negedge clk);
        syscall = 1'b0;
    endtask

    initial begin
        int n;
        #12;
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_valid", {31'd0, disp_valid}, 32'd0);
        chk("reset_count", 32'(sys_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Print with sink ready
        disp_ready = 1'b1;
        @(negedge clk);
        syscall = 1'b1; v0 = 32'd1; a0 = 32'h12345678;
        #1 chk("p1_issue_stall", {31'd0, stall}, 32'd1);
        @(negedge clk); syscall = 1'b0; #1;
        chk("p1_valid", {31'd0, disp_valid}, 32'd1);
        chk("p1_data", disp_data, 32'h12345678);
        chk("p1_stall", {31'd0, stall}, 32'd1);
        @(negedge clk); #1;
        chk("p1_valid_drop", {31'd0, disp_valid}, 32'd0);
        chk("p1_stall_drop", {31'd0, stall}, 32'd0);
        chk("p1_data_keep", disp_data, 32'h12345678);
        chk("p1_count", 32'(sys_count), 32'd1);

        // Print with backpressure
        disp_ready = 1'b0;
        @(negedge clk);
        syscall = 1'b1; v0 = 32'd34; a0 = 32'hDEADBEEF;
        #1 chk("p2_issue_stall", {31'd0, stall}, 32'd1);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); syscall = 1'b0;
            if (i == 5) disp_ready = 1'b1;
            #1;
            if (disp_valid && stall && disp_data == 32'hDEADBEEF) n++;
        end
        chk("p2_valid_cycles", n, 32'd6);
        @(negedge clk); disp_ready = 1'b0; #1;
        chk("p2_valid_drop", {31'd0, disp_valid}, 32'd0);
        chk("p2_stall_drop", {31'd0, stall}, 32'd0);
        chk("p2_count", 32'(sys_count), 32'd2);

        // Sleep: 1 + 3*4 stall cycles
        run_sys(32'd32, 32'd3, -1, n);
        chk("sleep3_cycles", n, 32'd13);
        chk("sleep3_count", 32'(sys_count), 32'd3);
        run_sys(32'd32, 32'd0, -1, n);
        chk("sleep0_cycles", n, 32'd0);
        chk("sleep0_count", 32'(sys_count), 32'd4);

        // Halt and resume
        @(negedge clk);
        syscall = 1'b1; v0 = 32'd10; a0 = 32'd0;
        #1 chk("halt_issue_stall", {31'd0, stall}, 32'd1);
        @(negedge clk); syscall = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_stall", {31'd0, stall}, 32'd1);
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0; #1;
        chk("resume_halted", {31'd0, halted}, 32'd0);
        chk("resume_stall", {31'd0, stall}, 32'd0);
        chk("halt_count", 32'(sys_count), 32'd5);
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0; #1;
        chk("go_idle_halted", {31'd0, halted}, 32'd0);
        chk("go_idle_stall", {31'd0, stall}, 32'd0);

        // Unknown code, then violation during sleep
        run_sys(32'd7, 32'd5, -1, n);
        chk("nop_cycles", n, 32'd0);
        chk("nop_count", 32'(sys_count), 32'd6);
        run_sys(32'd32, 32'd3, 4, n);
        chk("viol_sleep_cycles", n, 32'd13);
        chk("viol_count", 32'(sys_count), 32'd7);
        chk("viol_no_print", {31'd0, disp_valid}, 32'd0);

        // Async reset mid-PRINT
        disp_ready = 1'b0;
        @(negedge clk);
        syscall = 1'b1; v0 = 32'd1; a0 = 32'hCAFE0001;
        @(negedge clk); syscall = 1'b0;
        @(negedge clk); #1;
        chk("pre_rst_valid", {31'd0, disp_valid}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid", {31'd0, disp_valid}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_count", 32'(sys_count), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        disp_ready = 1'b1;
        run_sys(32'd1, 32'h00000042, -1, n);
        chk("post_rst_cycles", n, 32'd2);
        chk("post_rst_data", disp_data, 32'h00000042);
        chk("post_rst_count", 32'(sys_count), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/syscall_unit.md
Name: syscall_unit

Overview:
- Consumer side of the register file's $v0/$a0 taps: executes MIPS-style syscalls issued by the datapath.
- Decodes the service code in v0 and either prints the argument in a0 to the display through a valid/ready handshake, sleeps for a0 ticks, halts the CPU, or ignores the call.
- Sits beside the control unit. Drives a pipeline stall while a service is in progress.

Parameters:
- TICK_DIV, 1, clock cycles per sleep tick (1 = a0 counts raw cycles); must be >= 1
- CNT_W, 16, width of the syscall statistics counter

Ports:
- clk  in  1  system clock, rising-edge logic
- rst_n  in  1  asynchronous active-low reset
- syscall  in  1  high for one cycle when a SYSCALL instruction is in execute
- v0  in  32  register $2 contents (service code)
- a0  in  32  register $4 contents (argument)
- disp_ready  in  1  display sink accepts disp_data this cycle
- go  in  1  resume pulse from debounced button; leaves HALT
- stall  out  1  freeze PC and pipeline registers
- halted  out  1  CPU in halt state
- disp_data  out  32  value to show
- disp_valid  out  1  disp_data offered to sink
- sys_count  out  CNT_W  number of syscalls accepted since reset

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, stall=0, halted=0, disp_data=0, disp_valid=0, sys_count=0, sleep counters=0.
- Service codes are the full 32-bit value of v0:
  - 1 = print int
  - 34 = print hex
  - 32 = sleep
  - 10 = exit
  - anything else = no-op
- Display formatting is not this block's job. Codes 1 and 34 behave identically here.
- v0/a0 are stable at the rising edge: the register file writes on the falling edge.
- States: IDLE, PRINT, SLEEP, HALT.
- IDLE:
  - Samples syscall on each rising edge; every accepted syscall increments sys_count, wrapping modulo 2^CNT_W.
  - Code 1/34: disp_data<=a0, disp_valid<=1, go to PRINT.
  - Code 32 with a0!=0: load cnt<=a0, tick<=0, go to SLEEP.
  - Code 32 with a0==0: no-op, stay IDLE.
  - Code 10: go to HALT.
  - Other codes: no-op, stay IDLE.
- stall is combinational:
  - High in IDLE when syscall=1 and the code leads to a non-IDLE state. This covers the issue cycle, so the instruction after SYSCALL does not advance.
  - High in every cycle while in PRINT, SLEEP or HALT.
  - Low in the cycle the block returns to IDLE.
- PRINT:
  - disp_valid held high and disp_data held stable until the first rising edge with disp_ready=1.
  - At that edge: disp_valid<=0, go to IDLE.
  - disp_data keeps its last value after the handshake.
  - disp_ready may already be high on PRINT entry: the transfer then completes one cycle after issue (latency 1).
- SLEEP:
  - tick counts 0..TICK_DIV-1. When it wraps, cnt decrements.
  - When cnt reaches 0, go to IDLE.
  - Total stall cycles = 1 (issue) + a0*TICK_DIV.
  - a0 is treated as unsigned; 0xFFFFFFFF is legal and simply long.
- HALT:
  - halted=1, stall=1.
  - go=1 at a rising edge -> IDLE, halted=0.
  - go is ignored in all other states.
- syscall asserted while not in IDLE is a protocol violation. It is ignored: no count, no state change.
- Reset mid-service (any state) returns immediately to reset values. disp_valid drops without completing a handshake.

Decomposition:
- Shared package (mips_defs): SYS_PRINT_INT=1, SYS_PRINT_HEX=34, SYS_SLEEP=32, SYS_EXIT=10, and the 2-bit state encoding.
- One sub-module is natural: sleep_timer (TICK_DIV prescaler plus 32-bit down-counter with load/done).
- The FSM, handshake and statistics counter stay in syscall_unit.

Test Plan:
- Print, sink ready: v0=1, a0=0x12345678, disp_ready=1, one-cycle syscall -> stall high 2 cycles (issue, PRINT); disp_valid high 1 cycle with disp_data=0x12345678; sys_count=1.
- Print backpressure: v0=34, a0=0xDEADBEEF, disp_ready low 5 cycles then high -> disp_valid and disp_data stable for 6 cycles; stall drops the cycle after acceptance.
- Sleep: TICK_DIV=4, v0=32, a0=3 -> stall high exactly 13 cycles. Repeat with a0=0 -> stall never asserts; sys_count still increments.
- Halt/resume: v0=10 -> halted=1, stall=1; go pulsed while in HALT after 10 cycles -> IDLE next edge, halted=0, stall=0. go pulsed in IDLE -> no effect.
- Unknown code plus violation: v0=7 -> stall never high, sys_count increments. Syscall pulsed during SLEEP -> sys_count unchanged, sleep duration unchanged.
- Async reset during PRINT with disp_ready=0: assert rst_n low mid-cycle -> disp_valid, stall, halted and sys_count go to 0 without waiting for a clock edge; a syscall after release is serviced normally.
